// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the gshare PHT controller.
//   CNT_W        width of a 2-bit saturating direction counter
//   SNT/WNT/WT/ST counter encodings (strong/weak not-taken, weak/strong taken)
//   PHT_RST_VAL  value every table entry takes on reset (weakly not-taken)
//   ctrl_state_e update-control states IDLE/DRIVE/WRITE
package bp_pkg;

    localparam int CNT_W = 2;

    localparam logic [CNT_W-1:0] SNT = 2'b00;
    localparam logic [CNT_W-1:0] WNT = 2'b01;
    localparam logic [CNT_W-1:0] WT  = 2'b10;
    localparam logic [CNT_W-1:0] ST  = 2'b11;

    localparam logic [CNT_W-1:0] PHT_RST_VAL = WNT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WRITE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/bp_ghr.sv
// bp_ghr: global history shift register for the gshare predictor.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low reset (clears history to 0)
//   shift_en_i  shift a new outcome in this cycle
//   bit_i       outcome shifted into the LSB
//   ghr_o       current history, newest outcome in bit 0
// W must be at least 2.
module bp_ghr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en_i,
    input  logic         bit_i,
    output logic [W-1:0] ghr_o
);

    logic [W-1:0] ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (shift_en_i) begin
            ghr_d = {ghr_q[W-2:0], bit_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr_o = ghr_q;

endmodule

// File: rtl/bp_pht_ctrl.sv
// bp_pht_ctrl: gshare pattern history table with its global history, serving
// one-cycle prediction lookups and sequencing counter updates through the
// external counter FSM (fin_sta_mac), whose result is written back.
// Optional feature macro: BP_PHT_BYPASS_EN -- when defined, a lookup that hits
// the entry being written in the WRITE cycle returns fsm_next_i[1].
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   pred_req_i/pc_i     lookup request and branch PC
//   pred_vld_o/taken_o/idx_o  registered lookup response (1-cycle latency)
//   upd_vld_i/idx_i/taken_i   resolution update; upd_rdy_o = ready (IDLE)
//   fsm_cnt_o/torn_o    stored counter and actual outcome to the counter FSM
//   fsm_next_i          next counter value returned by the counter FSM
module bp_pht_ctrl
    import bp_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int IDX_W   = 6,
    parameter int GHR_W   = 6,
    parameter int FSM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_req_i,
    input  logic [PC_W-1:0]  pred_pc_i,
    output logic             pred_vld_o,
    output logic             pred_taken_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             upd_vld_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic             upd_rdy_o,
    output logic [CNT_W-1:0] fsm_cnt_o,
    output logic             fsm_torn_o,
    input  logic [CNT_W-1:0] fsm_next_i
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int LAT_W = (FSM_LAT > 1) ? $clog2(FSM_LAT) : 1;

    logic [CNT_W-1:0] pht_q [DEPTH];

    ctrl_state_e      state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
    logic             cap_taken_q, cap_taken_d;

    logic             pred_vld_q, pred_taken_q;
    logic [IDX_W-1:0] pred_idx_q;

    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] lkp_idx;
    logic             lkp_taken;
    logic             wr_en;
    logic             rdy_int;

    // Only the word-aligned index bits of the PC take part in the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0]};

    bp_ghr #(.W(GHR_W)) u_ghr (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (wr_en),
        .bit_i      (cap_taken_q),
        .ghr_o      (ghr)
    );

    // gshare hash; history is zero-extended to the index width.
    assign lkp_idx = pred_pc_i[IDX_W+1:2] ^ IDX_W'(ghr);

    // Table read happens before this cycle's write lands, so a same-index
    // lookup sees the old counter unless forwarding is built in.
    always_comb begin
        lkp_taken = pht_q[lkp_idx][CNT_W-1];
`ifdef BP_PHT_BYPASS_EN
        if (wr_en && (lkp_idx == cap_idx_q)) begin
            lkp_taken = fsm_next_i[CNT_W-1];
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        cap_idx_d   = cap_idx_q;
        cap_taken_d = cap_taken_q;
        rdy_int     = 1'b0;
        wr_en       = 1'b0;
        fsm_cnt_o   = '0;
        fsm_torn_o  = 1'b0;
        case (state_q)
            IDLE: begin
                rdy_int = 1'b1;
                if (upd_vld_i) begin
                    cap_idx_d   = upd_idx_i;
                    cap_taken_d = upd_taken_i;
                    lat_d       = '0;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                fsm_cnt_o  = pht_q[cap_idx_q];
                fsm_torn_o = cap_taken_q;
                if (lat_q == LAT_W'(FSM_LAT - 1)) begin
                    state_d = WRITE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            WRITE: begin
                fsm_cnt_o  = pht_q[cap_idx_q];
                fsm_torn_o = cap_taken_q;
                wr_en      = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is forced low while reset is being held.
    assign upd_rdy_o = rdy_int & reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            cap_idx_q   <= '0;
            cap_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            cap_idx_q   <= cap_idx_d;
            cap_taken_q <= cap_taken_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= PHT_RST_VAL;
            end
        end else if (wr_en) begin
            pht_q[cap_idx_q] <= fsm_next_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pred_vld_q   <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
        end else begin
            pred_vld_q <= pred_req_i;
            if (pred_req_i) begin
                pred_taken_q <= lkp_taken;
                pred_idx_q   <= lkp_idx;
            end
        end
    end

    assign pred_vld_o   = pred_vld_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_idx_o   = pred_idx_q;

endmodule
